pipe_addsub: RTL and testbench

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/addsub_pkg.sv | 24 ++
 rtl/add_slice.sv | 21 ++
 rtl/pipe_addsub.sv | 126 ++++++++++++
 tb/tb_pipe_addsub.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared constants and elaboration helpers for the pipelined
//               slice-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    // Pipeline depth: one stage per SLICE-bit group of the operands.
    function automatic int calc_stages(input int width, input int slice);
        return width / slice;
    endfunction

    // Geometry is legal only when the operand splits into whole slices.
    function automatic bit slice_ok(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/add_slice.sv
`default_nettype none
// ============================================================================
// Module      : add_slice
// Description : Combinational SLICE-bit adder with carry-in and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    // Widen by one bit so the slice carry falls out of the top.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

endmodule : add_slice
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipe_addsub
// Description : Pipelined adder/subtractor computing SLICE result bits per
//               stage with a single carry between stages. Operand slices are
//               skewed forward and result slices deskewed through the stage
//               registers so every beat leaves aligned. Valid/ready flow
//               control stalls the whole pipe when the output is blocked.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = calc_stages(WIDTH, SLICE);
    localparam int LAST   = STAGES - 1;

    if (!slice_ok(WIDTH, SLICE)) begin : g_bad_slice
        $error("pipe_addsub: WIDTH must be a non-zero multiple of SLICE");
    end

    // Per-stage registers. r_a/r_b carry the not-yet-consumed operand bits
    // (B already in its effective, possibly inverted, form); r_s holds the
    // result bits produced so far; r_c is the carry into the next stage.
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];

    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_co;
    logic [WIDTH-1:0]  w_a_in  [STAGES];
    logic [WIDTH-1:0]  w_b_in  [STAGES];
    logic [WIDTH-1:0]  w_s_in  [STAGES];
    logic [WIDTH-1:0]  w_s_new [STAGES];
    logic [SLICE-1:0]  w_ss    [STAGES];
    logic              w_adv;

    // The pipe moves only when the output slot is empty or being drained,
    // so out_ready never reaches the output registers combinationally.
    assign w_adv    = !r_v[LAST] || out_ready;
    assign in_ready = !rst && w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // Subtract as a + ~b + ~c_in; mode is folded into the operands
            // here, so later stages never need to know it.
            assign w_v_in[k] = in_valid;
            assign w_a_in[k] = a;
            assign w_b_in[k] = sub ? ~b : b;
            assign w_c_in[k] = sub ? ~c_in : c_in;
            assign w_s_in[k] = '0;
        end else begin : g_body
            assign w_v_in[k] = r_v[k-1];
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_c_in[k] = r_c[k-1];
            assign w_s_in[k] = r_s[k-1];
        end

        add_slice #(
            .SLICE (SLICE)
        ) u_add_slice (
            .a  (w_a_in[k][k*SLICE +: SLICE]),
            .b  (w_b_in[k][k*SLICE +: SLICE]),
            .ci (w_c_in[k]),
            .s  (w_ss[k]),
            .co (w_co[k])
        );

        // Unresolved upper result bits are zero, so OR-in the new slice.
        assign w_s_new[k] = w_s_in[k] | (WIDTH'(w_ss[k]) << (k * SLICE));
    end

    // Stage registers: clear on reset, freeze on stall, and only reload the
    // data of a slot that actually carries a beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_adv) begin
            r_v <= w_v_in;
            for (int k = 0; k < STAGES; k++) begin
                if (w_v_in[k]) begin
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                    r_s[k] <= w_s_new[k];
                    r_c[k] <= w_co[k];
                end
            end
        end
    end

    assign sum       = r_s[LAST];
    assign c_out     = r_c[LAST];
    assign out_valid = r_v[LAST];
    // Overflow from registered sign bits only; all-zero after reset gives 0.
    assign ovf = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1]) &&
                 (r_s[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);

endmodule : pipe_addsub
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_addsub
// Description : Self-checking bench for pipe_addsub (WIDTH=16, SLICE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a, b;
    logic             c_in, sub, in_valid, in_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out, ovf, out_valid, out_ready;

    pipe_addsub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        o;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] sum;
        logic        c;
        logic        o;
    } vec_t;

    res_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pop_cnt = 0, mark = 0, first_pop = 0, last_pop = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent arithmetic model: true subtraction and signed range test.
    function automatic res_t golden(input logic [15:0] ga, input logic [15:0] gb,
                                    input logic gc, input logic gs);
        res_t        r;
        int          sa, sb2, s;
        logic [16:0] t;
        sa  = int'($signed(ga));
        sb2 = int'($signed(gb));
        if (!gs) begin
            t   = {1'b0, ga} + {1'b0, gb} + {16'd0, gc};
            r.c = t[16];
            s   = sa + sb2 + (gc ? 1 : 0);
        end else begin
            t   = {1'b0, ga} - {1'b0, gb} - {16'd0, gc};
            r.c = !t[16];
            s   = sa - sb2 - (gc ? 1 : 0);
        end
        r.sum = t[15:0];
        r.o   = (s > 32767) || (s < -32768);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor and scoreboard; also checks the in_ready rule each cycle.
    always @(negedge clk) begin
        res_t e;
        if (rst) chk("in_ready_rst", {31'd0, in_ready}, 32'd0);
        else     chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum %h with empty scoreboard, expected none", sum);
            end else begin
                e = q.pop_front();
                chk("sum",   {16'd0, sum},   {16'd0, e.sum});
                chk("c_out", {31'd0, c_out}, {31'd0, e.c});
                chk("ovf",   {31'd0, ovf},   {31'd0, e.o});
            end
            if (pop_cnt == mark) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb2,
                        input logic tci, input logic tsb, input res_t e);
        int n = 0;
        a = ta; b = tb2; c_in = tci; sub = tsb; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0, expected 1");
        end else begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   n;
        int   k;
        logic sb;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, sum},       32'd0);
        chk("rst_c_out",     {31'd0, c_out},     32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Table vectors, one at a time, with latency measurement
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb,
                 res_t'{tbl[i].sum, tbl[i].c, tbl[i].o});
            in_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 20);
            chk("latency", n, LAT);
            @(posedge clk);
            #1;
        end

        // Back-to-back stream with alternating mode
        mark = pop_cnt;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [15:0] va, vb;
                    va = 16'(i * 16'h1111);
                    vb = 16'(j * 16'h1111) ^ 16'h0F0F;
                    sb = k[0];
                    send(va, vb, c[0], sb, golden(va, vb, c[0], sb));
                    k++;
                end
            end
        end
        in_valid = 1'b0;
        wait_drain();
        chk("stream_count", pop_cnt - mark, 512);
        chk("stream_span",  last_pop - first_pop, 511);

        // Output stall with four beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] va, vb;
            va = 16'h3FF0 + 16'(i * 16'h1357);
            vb = 16'h4011 + 16'(i * 16'h0F21);
            sb = i[0];
            send(va, vb, i[1], sb, golden(va, vb, i[1], sb));
        end
        in_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sum",   {16'd0, sum},   {16'd0, q[0].sum});
            chk("stall_c_out", {31'd0, c_out}, {31'd0, q[0].c});
            chk("stall_ovf",   {31'd0, ovf},   {31'd0, q[0].o});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        mark = pop_cnt;
        wait_drain();
        chk("stall_count", pop_cnt - mark, 4);

        // Reset pulse with three beats in flight
        for (int i = 0; i < 3; i++) begin
            send(16'h1111 * 16'(i + 1), 16'h2222, 1'b0, 1'b0,
                 golden(16'h1111 * 16'(i + 1), 16'h2222, 1'b0, 1'b0));
        end
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        mark = pop_cnt;
        send(16'hABCD, 16'h1234, 1'b1, 1'b1, golden(16'hABCD, 16'h1234, 1'b1, 1'b1));
        in_valid = 1'b0;
        wait_drain();
        chk("post_rst_count", pop_cnt - mark, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_addsub
`default_nettype wire
